streaming_pcoeff_accumulator: RTL and testbench
===============================================

// Module: streaming_pcoeff_accumulator
// PURPOSE
//  Sits directly downstream of the streaming connected-count core.
//  Consumes its in-order (resultValid, connectCount, extraDataOut, eccStatus) stream.
//  For every valid bot, adds the term 2^connectCount into a per-batch accumulator.
//  At each batch-end marker, hands {sum, botCount, eccError} to the output collector via valid/ready.
// PARAMETERS
//  ACC_WIDTH    48  accumulator/sum width; term bits >= ACC_WIDTH are out of range
//  COUNT_WIDTH  32  valid-bot counter width per batch; wraps modulo 2^COUNT_WIDTH
// PORTS
//  clk          in   1          single clock; all logic on posedge
//  rst_n        in   1          asynchronous active-low reset; all state cleared while low
//  resultValid  in   1          bot result present this cycle
//  connectCount in   6          connected-component count for this bot
//  isLastOfBatch in  1          batch-end marker (upstream extraDataOut bit); meaningful even if !resultValid
//  eccIn        in   1          upstream eccStatus, sampled every cycle
//  holdInput    out  1          upstream must stop issuing bots (output slot full)
//  outValid     out  1          batch result available
//  outReady     in   1          consumer accepts result when outValid && outReady
//  outSum       out  ACC_WIDTH  sum of 2^connectCount over the batch
//  outBotCount  out  COUNT_WIDTH number of valid bots in the batch
//  outEccError  out  1          any eccIn seen during the batch, including its last cycle
//  lostBatch    out  1          sticky: a batch result was dropped because both slots were full
// BEHAVIOUR
//  - Reset: all outputs and internal registers 0; both output slots empty.
//  - Stage 1 (cycle t): register inputs and compute term = resultValid ? (1<<connectCount) : 0.
//    If connectCount >= ACC_WIDTH, the term is 0 (see overflow option).
//  - Stage 2 (t+1): acc <= (clearPending ? 0 : acc) + term; cnt likewise +resultValid; eccAcc |= ecc.
//  - On a stage-2 cycle holding isLastOfBatch, the final {acc+term, cnt+v, eccAcc|ecc} is pushed to the output queue.
//    In the same cycle acc/cnt/eccAcc load 0, so a new batch's first bot at t+1 starts clean.
//  - Latency: last bot at input cycle t -> outValid high at t+2 if the queue was empty.
//  - Output queue: 2 entries (head register + skid register), FIFO order.
//    Pop on outValid&&outReady; push and pop in the same cycle are both honoured.
//  - Queue full: push with both entries full and no pop -> result discarded, lostBatch <= 1 (sticky until reset).
//  - holdInput = (skid entry occupied) || (head occupied && !outReady). Registered, 1 cycle late; upstream margin covers it.
//  - Empty batch (isLastOfBatch with resultValid=0 and no prior bots) emits sum=0, count=0.
//  - Stream values are never altered by holdInput; inputs are always consumed (no input stall).
//  - Reset mid-batch discards the partial accumulator and the queue contents.
// CONFIGURATION
//  PCOEFF_OVERFLOW_DETECT_EN defined: adds port outOverflow (out, 1), travelling with each queue entry.
//    It is set if any term was out of range or the stage-2 add carried out of ACC_WIDTH during the batch.
//  Not defined: port absent; out-of-range terms and carries are silently dropped (sum modulo 2^ACC_WIDTH).
// TESTING
//  1 reset: rst_n low mid-stream -> all outputs 0 while low; the first batch after release starts from sum 0.
//  2 batch of 3 bots cc={0,3,5}, last on 3rd, outReady=1 -> outSum=41, outBotCount=3, outValid 2 cycles after the last bot.
//  3 back-to-back batches {cc=2,last} then {cc=1,last} on consecutive cycles -> outputs 4 then 2; no cross-contamination.
//  4 outReady=0, three batch-ends -> first two queued, holdInput=1, lostBatch=1.
//    Then with outReady=1 the two queued results pop in order.
//  5 eccIn pulse on the last cycle of batch A only -> A outEccError=1, next batch B outEccError=0.
//  6 with PCOEFF_OVERFLOW_DETECT_EN, ACC_WIDTH=48: cc=48 -> outOverflow=1, outSum unchanged.
//    Two bots cc=47 -> carry out, outOverflow=1, outSum=0.

Source files
------------

// File: rtl/streaming_pcoeff_accumulator.sv
// Per-batch accumulator of 2^connectCount terms with a two-entry (head + skid) result queue.
// Optional build macro PCOEFF_OVERFLOW_DETECT_EN adds outOverflow, which travels with each queued batch.
module streaming_pcoeff_accumulator #(
   parameter int ACC_WIDTH   = 48,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   resultValid,
   input  logic [5:0]             connectCount,
   input  logic                   isLastOfBatch,
   input  logic                   eccIn,
   output logic                   holdInput,
   output logic                   outValid,
   input  logic                   outReady,
   output logic [ACC_WIDTH-1:0]   outSum,
   output logic [COUNT_WIDTH-1:0] outBotCount,
   output logic                   outEccError,
`ifdef PCOEFF_OVERFLOW_DETECT_EN
   output logic                   outOverflow,
`endif
   output logic                   lostBatch
);

   typedef struct packed {
      logic [ACC_WIDTH-1:0]   sum;
      logic [COUNT_WIDTH-1:0] cnt;
      logic                   ecc;
`ifdef PCOEFF_OVERFLOW_DETECT_EN
      logic                   ovf;
`endif
   } entry_t;

   // Stage 1: registered inputs and the already-shifted term.
   logic                 w_in_range;
   logic [ACC_WIDTH-1:0] w_term;
   logic [ACC_WIDTH-1:0] r_s1_term;
   logic                 r_s1_valid;
   logic                 r_s1_last;
   logic                 r_s1_ecc;

   // Stage 2: running batch state.
   logic [ACC_WIDTH-1:0]   r_acc;
   logic [COUNT_WIDTH-1:0] r_cnt;
   logic                   r_ecc_acc;
   logic [ACC_WIDTH-1:0]   w_sum;
   logic [COUNT_WIDTH-1:0] w_cnt_next;
   logic                   w_ecc_next;

   // Output queue.
   entry_t w_push_entry;
   entry_t r_head;
   entry_t r_skid;
   logic   r_head_vld;
   logic   r_skid_vld;
   logic   r_hold;
   logic   r_lost;
   logic   w_push;
   logic   w_pop;

   assign w_in_range = int'(connectCount) < ACC_WIDTH;
   assign w_term     = (resultValid && w_in_range) ? (ACC_WIDTH'(1) << connectCount) : '0;

`ifdef PCOEFF_OVERFLOW_DETECT_EN
   logic r_s1_oor;
   logic r_ovf_acc;
   logic w_carry;
   logic w_ovf_next;

   assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_s1_term};
   assign w_ovf_next       = r_ovf_acc | r_s1_oor | w_carry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_oor  <= 1'b0;
         r_ovf_acc <= 1'b0;
      end else begin
         r_s1_oor  <= resultValid && !w_in_range;
         r_ovf_acc <= r_s1_last ? 1'b0 : w_ovf_next;
      end
   end
`else
   assign w_sum = r_acc + r_s1_term;
`endif

   assign w_cnt_next = r_cnt + COUNT_WIDTH'(r_s1_valid);
   assign w_ecc_next = r_ecc_acc | r_s1_ecc;

   // NOTE: always_comb assigns every field a default first so no path can infer a latch.
   always_comb begin
      w_push_entry     = '0;
      w_push_entry.sum = w_sum;
      w_push_entry.cnt = w_cnt_next;
      w_push_entry.ecc = w_ecc_next;
`ifdef PCOEFF_OVERFLOW_DETECT_EN
      w_push_entry.ovf = w_ovf_next;
`endif
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_term  <= '0;
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_ecc   <= 1'b0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_ecc_acc  <= 1'b0;
      end else begin
         r_s1_term  <= w_term;
         r_s1_valid <= resultValid;
         r_s1_last  <= isLastOfBatch;
         r_s1_ecc   <= eccIn;
         // The batch that closes this cycle leaves clean state for a bot arriving right behind it.
         r_acc      <= r_s1_last ? '0 : w_sum;
         r_cnt      <= r_s1_last ? '0 : w_cnt_next;
         r_ecc_acc  <= r_s1_last ? 1'b0 : w_ecc_next;
      end
   end

   assign w_push = r_s1_last;
   assign w_pop  = r_head_vld && outReady;

   // NOTE: queue payload is reset along with the valid bits because it drives the outputs directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head     <= '0;
         r_skid     <= '0;
         r_head_vld <= 1'b0;
         r_skid_vld <= 1'b0;
         r_hold     <= 1'b0;
         r_lost     <= 1'b0;
      end else begin
         r_hold <= r_skid_vld || (r_head_vld && !outReady);
         if (w_pop) begin
            if (r_skid_vld) begin
               r_head     <= r_skid;
               r_skid_vld <= w_push;
               if (w_push) r_skid <= w_push_entry;
            end else if (w_push) begin
               r_head <= w_push_entry;
            end else begin
               r_head_vld <= 1'b0;
            end
         end else if (w_push) begin
            if (!r_head_vld) begin
               r_head     <= w_push_entry;
               r_head_vld <= 1'b1;
            end else if (!r_skid_vld) begin
               r_skid     <= w_push_entry;
               r_skid_vld <= 1'b1;
            end else begin
               r_lost <= 1'b1;
            end
         end
      end
   end

   assign holdInput   = r_hold;
   assign outValid    = r_head_vld;
   assign outSum      = r_head.sum;
   assign outBotCount = r_head.cnt;
   assign outEccError = r_head.ecc;
   assign lostBatch   = r_lost;
`ifdef PCOEFF_OVERFLOW_DETECT_EN
   assign outOverflow = r_head.ovf;
`endif

endmodule

// File: tb/tb_streaming_pcoeff_accumulator.sv
// Directed bench for streaming_pcoeff_accumulator; inputs change and outputs are sampled on negedge.
// Overflow checks are compiled in when PCOEFF_OVERFLOW_DETECT_EN is defined.
module tb_streaming_pcoeff_accumulator;

   localparam int ACC_WIDTH   = 48;
   localparam int COUNT_WIDTH = 32;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   resultValid;
   logic [5:0]             connectCount;
   logic                   isLastOfBatch;
   logic                   eccIn;
   logic                   holdInput;
   logic                   outValid;
   logic                   outReady;
   logic [ACC_WIDTH-1:0]   outSum;
   logic [COUNT_WIDTH-1:0] outBotCount;
   logic                   outEccError;
   logic                   lostBatch;
`ifdef PCOEFF_OVERFLOW_DETECT_EN
   logic                   outOverflow;
`endif

   int n_total = 0;
   int n_bad   = 0;

   streaming_pcoeff_accumulator #(.ACC_WIDTH(ACC_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .resultValid  (resultValid),
      .connectCount (connectCount),
      .isLastOfBatch(isLastOfBatch),
      .eccIn        (eccIn),
      .holdInput    (holdInput),
      .outValid     (outValid),
      .outReady     (outReady),
      .outSum       (outSum),
      .outBotCount  (outBotCount),
      .outEccError  (outEccError),
`ifdef PCOEFF_OVERFLOW_DETECT_EN
      .outOverflow  (outOverflow),
`endif
      .lostBatch    (lostBatch)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [5:0] cc, input logic last, input logic ecc);
      @(negedge clk);
      resultValid   = v;
      connectCount  = cc;
      isLastOfBatch = last;
      eccIn         = ecc;
   endtask

   task automatic idle();
      drive(1'b0, 6'd0, 1'b0, 1'b0);
   endtask

   task automatic expect_out(input string tag, input logic [63:0] sum, input logic [63:0] cnt,
                             input logic ecc);
      check({tag, "_valid"}, 64'(outValid), 64'd1);
      check({tag, "_sum"},   64'(outSum), sum);
      check({tag, "_cnt"},   64'(outBotCount), cnt);
      check({tag, "_ecc"},   64'(outEccError), 64'(ecc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; resultValid = 1'b0; connectCount = '0;
      isLastOfBatch = 1'b0; eccIn = 1'b0; outReady = 1'b0;

      // 1: reset state, then reset mid-stream with a queued result and a partial batch
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(outValid), 64'd0);
      check("rst_sum",   64'(outSum), 64'd0);
      check("rst_hold",  64'(holdInput), 64'd0);
      check("rst_lost",  64'(lostBatch), 64'd0);
      rst_n = 1'b1;
      drive(1'b1, 6'd3, 1'b1, 1'b0);
      idle();
      idle();
      expect_out("pre_rst", 64'd8, 64'd1, 1'b0);
      drive(1'b1, 6'd5, 1'b0, 1'b1);
      drive(1'b1, 6'd2, 1'b0, 1'b0);
      check("pre_rst_hold", 64'(holdInput), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(outValid), 64'd0);
      check("mid_rst_sum",   64'(outSum), 64'd0);
      check("mid_rst_cnt",   64'(outBotCount), 64'd0);
      check("mid_rst_hold",  64'(holdInput), 64'd0);
      idle();
      outReady = 1'b1;
      rst_n    = 1'b1;
      drive(1'b1, 6'd1, 1'b1, 1'b0);
      idle();
      idle();
      expect_out("post_rst", 64'd2, 64'd1, 1'b0);

      // 2: three-bot batch, latency of two edges after the last bot
      drive(1'b1, 6'd0, 1'b0, 1'b0);
      drive(1'b1, 6'd3, 1'b0, 1'b0);
      drive(1'b1, 6'd5, 1'b1, 1'b0);
      idle();
      check("t2_early", 64'(outValid), 64'd0);
      idle();
      expect_out("t2", 64'd41, 64'd3, 1'b0);
      idle();
      check("t2_popped", 64'(outValid), 64'd0);

      // 3: back-to-back single-bot batches
      drive(1'b1, 6'd2, 1'b1, 1'b0);
      drive(1'b1, 6'd1, 1'b1, 1'b0);
      idle();
      expect_out("t3a", 64'd4, 64'd1, 1'b0);
      idle();
      expect_out("t3b", 64'd2, 64'd1, 1'b0);
      idle();
      check("t3_empty", 64'(outValid), 64'd0);

      // 4: consumer stalled, third batch-end is dropped, then drain in order
      outReady = 1'b0;
      drive(1'b1, 6'd0, 1'b1, 1'b0);
      drive(1'b1, 6'd1, 1'b1, 1'b0);
      drive(1'b1, 6'd2, 1'b1, 1'b0);
      idle();
      idle();
      idle();
      check("t4_hold", 64'(holdInput), 64'd1);
      check("t4_lost", 64'(lostBatch), 64'd1);
      expect_out("t4a", 64'd1, 64'd1, 1'b0);
      outReady = 1'b1;
      idle();
      expect_out("t4b", 64'd2, 64'd1, 1'b0);
      idle();
      check("t4_drained", 64'(outValid), 64'd0);
      check("t4_hold_off", 64'(holdInput), 64'd0);
      check("t4_lost_sticky", 64'(lostBatch), 64'd1);

      // 5: ECC on the last cycle of batch A only
      drive(1'b1, 6'd0, 1'b0, 1'b0);
      drive(1'b1, 6'd1, 1'b1, 1'b1);
      drive(1'b1, 6'd2, 1'b1, 1'b0);
      idle();
      expect_out("t5a", 64'd3, 64'd2, 1'b1);
      idle();
      expect_out("t5b", 64'd4, 64'd1, 1'b0);

      // empty batch
      drive(1'b0, 6'd7, 1'b1, 1'b0);
      idle();
      idle();
      expect_out("empty", 64'd0, 64'd0, 1'b0);

      // 6: out-of-range term, carry out, and the top in-range term
      drive(1'b1, 6'd48, 1'b1, 1'b0);
      idle();
      idle();
      expect_out("t6_oor", 64'd0, 64'd1, 1'b0);
`ifdef PCOEFF_OVERFLOW_DETECT_EN
      check("t6_oor_ovf", 64'(outOverflow), 64'd1);
`endif
      drive(1'b1, 6'd47, 1'b0, 1'b0);
      drive(1'b1, 6'd47, 1'b1, 1'b0);
      idle();
      idle();
      expect_out("t6_carry", 64'd0, 64'd2, 1'b0);
`ifdef PCOEFF_OVERFLOW_DETECT_EN
      check("t6_carry_ovf", 64'(outOverflow), 64'd1);
`endif
      drive(1'b1, 6'd47, 1'b1, 1'b0);
      idle();
      idle();
      expect_out("t6_top", 64'h0000_8000_0000_0000, 64'd1, 1'b0);
`ifdef PCOEFF_OVERFLOW_DETECT_EN
      check("t6_top_ovf", 64'(outOverflow), 64'd0);
`endif

      idle();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
